// File: rtl/apb_regfile_pkg.sv
// Shared types and helpers for the parametrised APB register file.
// Byte-lane merge is only referenced when APB_REGFILE_PSTRB_EN is defined.
package apb_regfile_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int CNT_W = 4;

  // Lanes wider than the real data bus are simply ignored by the caller.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_regfile_param_if.sv
// APB3 bus bundle for apb_regfile_param; pstrb exists only with APB_REGFILE_PSTRB_EN.
interface apb_regfile_param_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
`ifdef APB_REGFILE_PSTRB_EN
  logic [DATA_W/8-1:0] pstrb;
`endif
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

`ifdef APB_REGFILE_PSTRB_EN
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata, pstrb,
                  output prdata, pready, pslverr);
`else
  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
`endif

endinterface

// File: rtl/apb_access_fsm.sv
// APB access-phase sequencer with WAIT_CYCLES programmable wait states.
//   state  | meaning
//   IDLE   | no transfer; waits for a setup phase (psel=1, penable=0)
//   ACCESS | access phase; cnt counts wait states up to WAIT_CYCLES
module apb_access_fsm
  import apb_regfile_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic pclk,
  input  logic preset_n,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic commit
);

  localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(WAIT_CYCLES);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (psel && !penable) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        // Deselect mid-access is an abort; the top sees no commit.
        if (!psel)                state_nxt = IDLE;
        else if (cnt != WAIT_TC)  cnt_nxt   = cnt + 1'b1;
        else                      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pready = (state == ACCESS) && (cnt == WAIT_TC);
    commit = pready && psel && penable;
  end

endmodule

// File: rtl/apb_regfile_param.sv
// Parametrised APB3 register file: NUM_REGS x DATA_W registers, flat reg_q output.
// Optional byte strobes are enabled with APB_REGFILE_PSTRB_EN.
module apb_regfile_param
  import apb_regfile_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  apb_regfile_param_if.slave         bus,
  output logic [NUM_REGS*DATA_W-1:0] reg_q
);

  logic              commit;
  logic              addr_legal;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;

  apb_access_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .pclk     (pclk),
    .preset_n (preset_n),
    .psel     (bus.psel),
    .penable  (bus.penable),
    .pready   (bus.pready),
    .commit   (commit)
  );

  assign addr_legal = 32'(bus.paddr) < 32'(NUM_REGS);
  assign wr_en      = commit && bus.pwrite && addr_legal;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      reg_q <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (bus.paddr == ADDR_W'(i)) begin
`ifdef APB_REGFILE_PSTRB_EN
          reg_q[i*DATA_W +: DATA_W] <= DATA_W'(lane_merge(32'(reg_q[i*DATA_W +: DATA_W]),
                                                          32'(bus.pwdata),
                                                          4'(bus.pstrb)));
`else
          reg_q[i*DATA_W +: DATA_W] <= bus.pwdata;
`endif
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.paddr == ADDR_W'(i)) rd_word = reg_q[i*DATA_W +: DATA_W];
    end
  end

  // Read data and error are only driven in the completion cycle so the bus idles at zero.
  assign bus.prdata  = (bus.pready && !bus.pwrite && addr_legal) ? rd_word : '0;
  assign bus.pslverr = bus.pready && !addr_legal;

endmodule
